// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter in front of the single-port activation SRAM.
// Accepts one command per cycle from NREQ requesters, drives a registered SRAM
// command port, and returns read data tagged with the requester ID after
// 2+RD_LAT cycles. Also counts cycles in which two or more requesters contend.
module sram_arbiter #(
    parameter int BITWIDTH = 256,
    parameter int WIDTH    = 16,
    parameter int NREQ     = 4,
    parameter int RD_LAT   = 1,
    localparam int IDW     = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                                   CKL_i,
    input  logic                                   RST_i,
    input  logic [NREQ-1:0]                        req_valid_i,
    output logic [NREQ-1:0]                        req_ready_o,
    input  logic [NREQ-1:0]                        req_we_i,
    input  logic [NREQ-1:0][WIDTH-1:0]             req_addr_i,
    input  logic [NREQ-1:0][BITWIDTH-1:0][WIDTH-1:0] req_wdata_i,
    output logic                                   sram_ce_o,
    output logic                                   sram_we_o,
    output logic [WIDTH-1:0]                       sram_addr_o,
    output logic [BITWIDTH-1:0][WIDTH-1:0]         sram_wdata_o,
    input  logic [BITWIDTH-1:0][WIDTH-1:0]         sram_rdata_i,
    output logic                                   rsp_valid_o,
    output logic [IDW-1:0]                         rsp_id_o,
    output logic [BITWIDTH-1:0][WIDTH-1:0]         rsp_rdata_o,
    output logic [31:0]                            conflict_cnt_o
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] win_id;
    logic           grant_any;
    logic [IDW-1:0] issue_id_q;
    logic           tag_vld_q [RD_LAT];
    logic [IDW-1:0] tag_id_q  [RD_LAT];
    logic [31:0]    cnt_q;

    // Requester index p+k folded back into 0..NREQ-1.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // Grant the first valid requester at or after ptr, searching upward.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        req_ready_o = '0;
        win_id      = '0;
        grant_any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && req_valid_i[rr_idx(ptr_q, k)]) begin
                grant_any                     = 1'b1;
                win_id                        = rr_idx(ptr_q, k);
                req_ready_o[rr_idx(ptr_q, k)] = 1'b1;
            end
        end
    end

    // Priority pointer moves just past the last winner; holds when idle.
    always_ff @(posedge CKL_i or negedge RST_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!RST_i) begin
            ptr_q <= '0;
        end else if (grant_any) begin
            ptr_q <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
        end
    end

    // Register the winning command onto the SRAM port; addr/wdata hold when idle.
    always_ff @(posedge CKL_i or negedge RST_i) begin
        if (!RST_i) begin
            sram_ce_o    <= 1'b0;
            sram_we_o    <= 1'b0;
            sram_addr_o  <= '0;
            sram_wdata_o <= '0;
            issue_id_q   <= '0;
        end else begin
            sram_ce_o <= grant_any;
            sram_we_o <= grant_any & req_we_i[win_id];
            if (grant_any) begin
                sram_addr_o  <= req_addr_i[win_id];
                sram_wdata_o <= req_wdata_i[win_id];
                issue_id_q   <= win_id;
            end
        end
    end

    // Tag pipeline: one stage per SRAM read-latency cycle, loaded on the issue cycle.
    always_ff @(posedge CKL_i or negedge RST_i) begin
        if (!RST_i) begin
            // NOTE: the tag pipeline is reset (unlike a data-only array) because
            // a stale valid bit would emit a phantom response after reset.
            for (int k = 0; k < RD_LAT; k++) begin
                tag_vld_q[k] <= 1'b0;
                tag_id_q[k]  <= '0;
            end
        end else begin
            tag_vld_q[0] <= sram_ce_o & ~sram_we_o;
            tag_id_q[0]  <= issue_id_q;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
        end
    end

    // Capture SRAM read data when its tag leaves the pipeline; data holds otherwise.
    always_ff @(posedge CKL_i or negedge RST_i) begin
        if (!RST_i) begin
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_rdata_o <= '0;
        end else begin
            rsp_valid_o <= tag_vld_q[RD_LAT-1];
            if (tag_vld_q[RD_LAT-1]) begin
                rsp_id_o    <= tag_id_q[RD_LAT-1];
                rsp_rdata_o <= sram_rdata_i;
            end
        end
    end

    // Saturating count of cycles with two or more valid requests.
    always_ff @(posedge CKL_i or negedge RST_i) begin
        if (!RST_i) begin
            cnt_q <= '0;
        end else if (($countones(req_valid_i) >= 2) && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign conflict_cnt_o = cnt_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Round-robin arbiter that shares the single-port activation SRAM between NREQ requesters (DMA loader, PE array readback, writeback, host debug). It accepts one read or write command per cycle via a valid/ready handshake and drives a registered SRAM command port. It tracks in-flight reads through a tag pipeline and returns read data tagged with the requester ID. It sits between the requesters and the SRAM pass-through controller.

## Interface
- BITWIDTH, 256: lanes per SRAM word.
- WIDTH, 16: bits per lane; also address width.
- NREQ, 4: number of requesters, 2..8.
- RD_LAT, 1: SRAM read latency in cycles, 1..4, from the sram_ce_o cycle to valid sram_rdata_i.
- IDW = max(1, $clog2(NREQ)), derived.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- CKL_i  in  1  clock; all state is updated on the rising edge.
- RST_i  in  1  reset; asynchronous assert, active-low.
- req_valid_i  in  [NREQ]  command valid, per requester.
- req_ready_o  out  [NREQ]  grant; the command is accepted when valid & ready.
- req_we_i  in  [NREQ]  1 = write, 0 = read.
- req_addr_i  in  [NREQ][WIDTH]  word address.
- req_wdata_i  in  [NREQ][BITWIDTH][WIDTH]  write data.
- sram_ce_o  out  1  SRAM access enable, registered.
- sram_we_o  out  1  SRAM write enable, registered.
- sram_addr_o  out  [WIDTH]  registered address.
- sram_wdata_o  out  [BITWIDTH][WIDTH]  registered write data.
- sram_rdata_i  in  [BITWIDTH][WIDTH]  SRAM read data.
- rsp_valid_o  out  1  read response valid, one-cycle pulse; no backpressure.
- rsp_id_o  out  [IDW]  ID of the requester that issued the read.
- rsp_rdata_o  out  [BITWIDTH][WIDTH]  read data.
- conflict_cnt_o  out  32  saturating count of cycles with ≥2 valid requests.

## Operation
- Arbitration:
  - Combinational; at most one req_ready_o bit is high per cycle.
  - The grant goes to the first valid requester at or after the priority pointer ptr, searching upward modulo NREQ.
  - req_ready_o[i] is never high while req_valid_i[i] is low.
  - No grant is issued when no request is valid.
- Pointer:
  - Resets to 0.
  - After a grant to i, ptr = (i+1) mod NREQ.
  - With no grant, ptr holds its value.
- Issue:
  - On acceptance, register ce=1, we, addr and wdata of the winner into the sram_* outputs.
  - Otherwise the next cycle drives sram_ce_o=0 and sram_we_o=0; addr and wdata hold their previous values.
- Read tracking:
  - A shift pipeline of depth RD_LAT carries {valid, id} for each issued read.
  - When the tag reaches the end of the pipeline, register rsp_valid_o=1, rsp_id_o=id and rsp_rdata_o=sram_rdata_i.
  - Writes enter the pipeline with valid=0 and produce no response.
- Ordering:
  - Commands execute in acceptance order; a read after a write to the same address returns the new data.
  - Responses return in issue order.
- Counter: conflict_cnt_o increments when popcount(req_valid_i) ≥ 2 and saturates at 0xFFFF_FFFF.
- Reset mid-operation:
  - All in-flight read tags are discarded; no rsp_valid_o appears for them.
  - ptr, the counter and all outputs are cleared immediately.

## Timing
- Reset values:
  - sram_ce_o=0, sram_we_o=0, sram_addr_o=0, sram_wdata_o=0.
  - rsp_valid_o=0, rsp_id_o=0, rsp_rdata_o=0.
  - conflict_cnt_o=0; ptr=0.
- req_ready_o is combinational from req_valid_i and ptr.
- Accept at cycle t:
  - sram_ce_o is high in cycle t+1.
  - sram_rdata_i is valid at t+1+RD_LAT.
  - rsp_valid_o is high at t+2+RD_LAT, so read latency is 2+RD_LAT (3 at default).
- Throughput is one command per cycle; back-to-back grants give a continuous sram_ce_o.
- rsp_valid_o pulses for exactly one cycle per read; rsp_rdata_o holds its value until the next response.

## Test plan
- Single read: requester 2 reads addr 0x0010, where the SRAM model holds a lane pattern of 0x0010+lane.
  - req_ready_o=4'b0100 in the same cycle.
  - sram_ce_o=1 with addr 0x0010 at t+1.
  - rsp_valid_o=1 with rsp_id_o=2 and the correct data at t+3.
  - sram_ce_o=0 at all other cycles.
- Round-robin fairness: all four requesters hold valid for 8 cycles.
  - Grants follow 0,1,2,3,0,1,2,3.
  - conflict_cnt_o=8 afterwards.
- Read-after-write: requester 1 writes 0xABCD to all lanes at addr 5; requester 3 reads addr 5 in the next cycle.
  - The response has id 3 and every lane equals 0xABCD.
- Sparse fairness: requesters 0 and 3 are valid continuously and ptr starts at 1.
  - Grants follow 3,0,3,0.
  - Requesters 1 and 2 are never granted.
- Reset mid-flight: assert RST_i low one cycle after a read is accepted.
  - All outputs read 0 immediately.
  - No rsp_valid_o appears after release.
  - The next grant follows ptr=0.
- Counter saturation: preload the counter to 0xFFFF_FFFE, then apply 3 conflict cycles.
  - conflict_cnt_o=0xFFFF_FFFF and it stays there.
